reg_writeback: RTL and testbench

Writeback stage for the bexkat2 integer register file. Merges single-cycle ALU results and variable-latency memory load results into the file's single write port (`write_addr`/`write_data`/`write_en`), buffering loads in a small FIFO. Keeps a per-register pending-load scoreboard, including a separate bit for the supervisor stack pointer, and flags read hazards to the decode stage.

---
 rtl/reg_writeback.sv | 260 ++++++++++++++++++++++++++
 tb/tb_reg_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback -- writeback stage for the bexkat2 integer register file.
//
// Merges single-cycle ALU results and variable-latency load results onto the
// register file's single write port. Loads that cannot be written right away
// wait in a small FIFO. A pending-load scoreboard (one bit per register plus
// a separate bit for the supervisor stack pointer) drives the read-hazard
// flags used by decode.
//
// Configuration macro: REGWB_SIGNEXT_EN
//   defined   : signed byte/half loads are sign-extended to WIDTH and written
//               with write_en = 11.
//   undefined : mem_signed is ignored; the size passes through unchanged.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-low reset
//   alu_valid/addr/super/data/size   ALU result (always accepted)
//   mem_valid/ready/addr/super/data/size/signed   load result handshake
//   issue_valid/addr/super     load issued: mark destination busy
//   supervisor                 current mode, selects r15 vs ssp for lookups
//   read1, read2 / hazard1, hazard2  decode source registers and hazards
//   write_addr/data/en/super   register-file write port
//   idle                       FIFO empty, no busy bits, no write in flight
// ---------------------------------------------------------------------------
module reg_writeback #(
    parameter int WIDTH  = 32,
    parameter int COUNT  = 16,
    parameter int COUNTP = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid,
    input  logic [COUNTP-1:0] alu_addr,
    input  logic              alu_super,
    input  logic [WIDTH-1:0]  alu_data,
    input  logic [1:0]        alu_size,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [COUNTP-1:0] mem_addr,
    input  logic              mem_super,
    input  logic [WIDTH-1:0]  mem_data,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic              issue_valid,
    input  logic [COUNTP-1:0] issue_addr,
    input  logic              issue_super,
    input  logic              supervisor,
    input  logic [COUNTP-1:0] read1,
    input  logic [COUNTP-1:0] read2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [COUNTP-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [1:0]        write_en,
    output logic              write_super,
    output logic              idle
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int IDXW = $clog2(COUNT + 1);
    localparam logic [COUNTP-1:0] STACK_REG = COUNTP'(COUNT - 1);
    localparam logic [IDXW-1:0]   SSP_IDX   = IDXW'(COUNT);
    localparam logic [PTRW:0]     PTR_ONE   = (PTRW + 1)'(1);

    // Scoreboard index: the top register with the super flag maps to the
    // extra ssp slot, everything else maps to its own address.
    function automatic logic [IDXW-1:0] sb_index(input logic [COUNTP-1:0] addr,
                                                 input logic sup);
        return (sup && (addr == STACK_REG)) ? SSP_IDX : IDXW'(addr);
    endfunction

    // ------------------------------------------------------------------
    // Load FIFO
    // ------------------------------------------------------------------
    logic [COUNTP-1:0] fifo_addr_q  [DEPTH];
    logic              fifo_super_q [DEPTH];
    logic [WIDTH-1:0]  fifo_data_q  [DEPTH];
    logic [1:0]        fifo_size_q  [DEPTH];
`ifdef REGWB_SIGNEXT_EN
    logic              fifo_signed_q [DEPTH];
`else
    logic              unused_mem_signed;
    assign unused_mem_signed = mem_signed;
`endif

    // Pointers carry one extra bit so full and empty can be told apart.
    logic [PTRW:0] wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full;
    logic          alu_sel, mem_take, push, pop, bypass;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTRW] != rd_ptr_q[PTRW]) &&
                        (wr_ptr_q[PTRW-1:0] == rd_ptr_q[PTRW-1:0]);
    assign mem_ready  = !fifo_full;

    assign alu_sel  = alu_valid && (alu_size != 2'b00);
    // A load goes out when the ALU is quiet and either the FIFO has an
    // entry or a new load arrives at an empty FIFO. The latter bypasses
    // storage so an uncontended load is written the following cycle.
    assign mem_take = !alu_sel && (!fifo_empty || mem_valid);
    assign pop      = mem_take && !fifo_empty;
    assign bypass   = mem_take && fifo_empty;
    assign push     = mem_valid && !fifo_full && !bypass;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[PTRW-1:0]]   <= mem_addr;
            fifo_super_q[wr_ptr_q[PTRW-1:0]]  <= mem_super;
            fifo_data_q[wr_ptr_q[PTRW-1:0]]   <= mem_data;
            fifo_size_q[wr_ptr_q[PTRW-1:0]]   <= mem_size;
`ifdef REGWB_SIGNEXT_EN
            fifo_signed_q[wr_ptr_q[PTRW-1:0]] <= mem_signed;
`endif
        end
    end

    // Load candidate: FIFO head, or the incoming load when bypassing.
    logic [COUNTP-1:0] cand_addr;
    logic              cand_super;
    logic [WIDTH-1:0]  cand_data;
    logic [1:0]        cand_size;
    logic [WIDTH-1:0]  cand_data_x;
    logic [1:0]        cand_size_x;
`ifdef REGWB_SIGNEXT_EN
    logic              cand_signed;
`endif

    always_comb begin
        cand_addr  = fifo_addr_q[rd_ptr_q[PTRW-1:0]];
        cand_super = fifo_super_q[rd_ptr_q[PTRW-1:0]];
        cand_data  = fifo_data_q[rd_ptr_q[PTRW-1:0]];
        cand_size  = fifo_size_q[rd_ptr_q[PTRW-1:0]];
`ifdef REGWB_SIGNEXT_EN
        cand_signed = fifo_signed_q[rd_ptr_q[PTRW-1:0]];
`endif
        if (fifo_empty) begin
            cand_addr  = mem_addr;
            cand_super = mem_super;
            cand_data  = mem_data;
            cand_size  = mem_size;
`ifdef REGWB_SIGNEXT_EN
            cand_signed = mem_signed;
`endif
        end
    end

    always_comb begin
        cand_data_x = cand_data;
        cand_size_x = cand_size;
`ifdef REGWB_SIGNEXT_EN
        if (cand_signed) begin
            if (cand_size == 2'b01) begin
                cand_data_x = {{(WIDTH-8){cand_data[7]}}, cand_data[7:0]};
                cand_size_x = 2'b11;
            end else if (cand_size == 2'b10) begin
                cand_data_x = {{(WIDTH-16){cand_data[15]}}, cand_data[15:0]};
                cand_size_x = 2'b11;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    logic [COUNTP-1:0] write_addr_q, write_addr_d;
    logic [WIDTH-1:0]  write_data_q, write_data_d;
    logic [1:0]        write_en_q, write_en_d;
    logic              write_super_q, write_super_d;
    logic              load_wr_q, load_wr_d;   // current write came from a load

    always_comb begin
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        write_super_d = write_super_q;
        write_en_d    = 2'b00;
        load_wr_d     = 1'b0;
        // write_super is normalised so it is only ever set for the ssp,
        // which keeps the hazard compare and busy clear index consistent.
        if (alu_sel) begin
            write_addr_d  = alu_addr;
            write_data_d  = alu_data;
            write_en_d    = alu_size;
            write_super_d = alu_super && (alu_addr == STACK_REG);
        end else if (mem_take) begin
            write_addr_d  = cand_addr;
            write_data_d  = cand_data_x;
            write_en_d    = cand_size_x;
            write_super_d = cand_super && (cand_addr == STACK_REG);
            load_wr_d     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: a load write clears its bit on the edge that ends
    // the write cycle; a same-cycle issue to the same slot takes priority.
    // ------------------------------------------------------------------
    logic [COUNT:0]  busy_q, busy_d;
    logic [IDXW-1:0] set_idx, clr_idx;

    assign set_idx = sb_index(issue_addr, issue_super);
    assign clr_idx = sb_index(write_addr_q, write_super_q);

    genvar gi;
    generate
        for (gi = 0; gi <= COUNT; gi++) begin : g_busy
            assign busy_d[gi] = (issue_valid && (set_idx == IDXW'(gi))) ||
                                (busy_q[gi] && !(load_wr_q && (clr_idx == IDXW'(gi))));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            busy_q        <= '0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            write_en_q    <= 2'b00;
            write_super_q <= 1'b0;
            load_wr_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            busy_q        <= busy_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            write_en_q    <= write_en_d;
            write_super_q <= write_super_d;
            load_wr_q     <= load_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Hazards: pending load, or a write on the port this cycle that the
    // register file has not captured yet.
    // ------------------------------------------------------------------
    logic [IDXW-1:0] rd1_idx, rd2_idx;
    assign rd1_idx = sb_index(read1, supervisor);
    assign rd2_idx = sb_index(read2, supervisor);

    assign hazard1 = busy_q[rd1_idx] ||
                     ((write_en_q != 2'b00) && (write_addr_q == read1) &&
                      (write_super_q == (supervisor && (read1 == STACK_REG))));
    assign hazard2 = busy_q[rd2_idx] ||
                     ((write_en_q != 2'b00) && (write_addr_q == read2) &&
                      (write_super_q == (supervisor && (read2 == STACK_REG))));

    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
    assign write_en    = write_en_q;
    assign write_super = write_super_q;
    assign idle        = fifo_empty && (busy_q == '0) && (write_en_q == 2'b00);

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback -- directed bench for reg_writeback.
// Stimulus pushes every expected register-file write (fields plus the cycle
// it must appear in) into a queue; a monitor on the falling edge pops and
// compares each write the DUT presents. Hazard/ready/idle flags are checked
// inline against hand-computed values.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

    localparam int WIDTH  = 32;
    localparam int COUNT  = 16;
    localparam int COUNTP = 4;
    localparam int DEPTH  = 4;
`ifdef REGWB_SIGNEXT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              alu_valid = 1'b0;
    logic [COUNTP-1:0] alu_addr = '0;
    logic              alu_super = 1'b0;
    logic [WIDTH-1:0]  alu_data = '0;
    logic [1:0]        alu_size = 2'b00;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [COUNTP-1:0] mem_addr = '0;
    logic              mem_super = 1'b0;
    logic [WIDTH-1:0]  mem_data = '0;
    logic [1:0]        mem_size = 2'b00;
    logic              mem_signed = 1'b0;
    logic              issue_valid = 1'b0;
    logic [COUNTP-1:0] issue_addr = '0;
    logic              issue_super = 1'b0;
    logic              supervisor = 1'b0;
    logic [COUNTP-1:0] read1 = '0;
    logic [COUNTP-1:0] read2 = '0;
    logic              hazard1, hazard2;
    logic [COUNTP-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [1:0]        write_en;
    logic              write_super;
    logic              idle;

    reg_writeback #(
        .WIDTH (WIDTH),
        .COUNT (COUNT),
        .COUNTP(COUNTP),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_super  (alu_super),
        .alu_data   (alu_data),
        .alu_size   (alu_size),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_super  (mem_super),
        .mem_data   (mem_data),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .issue_super(issue_super),
        .supervisor (supervisor),
        .read1      (read1),
        .read2      (read2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .write_super(write_super),
        .idle       (idle)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [1:0]  en;
        logic        sup;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Scoreboard monitor
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && (write_en != 2'b00)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d super=%0d data=%h en=%b required no write",
                         cyc, write_addr, write_super, write_data, write_en);
            end else begin
                e = exp_q.pop_front();
                $display("WB cyc=%0d addr=%0d super=%0d data=%h en=%b",
                         cyc, write_addr, write_super, write_data, write_en);
                if (write_addr !== e.addr || write_data !== e.data || write_en !== e.en ||
                    write_super !== e.sup || cyc != e.at) begin
                    failures++;
                    $display("FAIL write got cyc=%0d addr=%0d sup=%0d data=%h en=%b required cyc=%0d addr=%0d sup=%0d data=%h en=%b",
                             cyc, write_addr, write_super, write_data, write_en,
                             e.at, e.addr, e.sup, e.data, e.en);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] en,
                             input logic s, input int at);
        exp_t e;
        e.addr = a; e.data = d; e.en = en; e.sup = s; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] a, input logic s,
                           input logic [31:0] d, input logic [1:0] sz);
        alu_valid = v; alu_addr = a; alu_super = s; alu_data = d; alu_size = sz;
    endtask

    task automatic set_mem(input logic v, input logic [3:0] a, input logic s,
                           input logic [31:0] d, input logic [1:0] sz, input logic sg);
        mem_valid = v; mem_addr = a; mem_super = s; mem_data = d; mem_size = sz; mem_signed = sg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired required finish");
        $fatal(1);
    end

    initial begin
        int k;
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_write_en", 32'(write_en), 32'h0);
        chk("rst_write_addr", 32'(write_addr), 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        chk("rst_write_super", 32'(write_super), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h1);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_hazard1", 32'(hazard1), 32'h0);
        chk("rst_hazard2", 32'(hazard2), 32'h0);
        rst_i = 1'b1;
        tick();

        // ---------------- ALU single write ----------------
        k = cyc;
        set_alu(1'b1, 4'd3, 1'b0, 32'h12345678, 2'b11);
        expect_wr(4'd3, 32'h12345678, 2'b11, 1'b0, k + 1);
        tick();
        set_alu(1'b0, 4'd0, 1'b0, 32'h0, 2'b00);
        read2 = 4'd3;
        #1;
        chk("hazard2_inflight_r3", 32'(hazard2), 32'h1);
        chk("idle_during_write", 32'(idle), 32'h0);
        tick();
        chk("hazard2_after_r3", 32'(hazard2), 32'h0);
        chk("idle_after_alu", 32'(idle), 32'h1);
        read2 = 4'd0;

        // ---------------- load r5 delayed by 3 ALU cycles ----------------
        issue_valid = 1'b1; issue_addr = 4'd5; issue_super = 1'b0;
        tick();
        issue_valid = 1'b0;
        read1 = 4'd5;
        #1;
        chk("hazard1_busy_r5", 32'(hazard1), 32'h1);
        k = cyc;
        set_alu(1'b1, 4'd1, 1'b0, 32'h00000011, 2'b11);
        set_mem(1'b1, 4'd5, 1'b0, 32'h000000AB, 2'b01, 1'b0);
        expect_wr(4'd1, 32'h00000011, 2'b11, 1'b0, k + 1);
        tick();
        set_mem(1'b0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0);
        set_alu(1'b1, 4'd6, 1'b0, 32'h00000066, 2'b11);
        expect_wr(4'd6, 32'h00000066, 2'b11, 1'b0, k + 2);
        tick();
        set_alu(1'b1, 4'd7, 1'b0, 32'h00000077, 2'b11);
        expect_wr(4'd7, 32'h00000077, 2'b11, 1'b0, k + 3);
        expect_wr(4'd5, 32'h000000AB, 2'b01, 1'b0, k + 4);
        tick();
        set_alu(1'b0, 4'd0, 1'b0, 32'h0, 2'b00);
        #1;
        chk("hazard1_r5_queued", 32'(hazard1), 32'h1);
        tick();
        chk("hazard1_r5_write_cycle", 32'(hazard1), 32'h1);
        tick();
        chk("hazard1_r5_cleared", 32'(hazard1), 32'h0);
        chk("idle_after_r5", 32'(idle), 32'h1);
        read1 = 4'd0;

        // ---------------- fill FIFO under ALU traffic ----------------
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            set_alu(1'b1, 4'd9, 1'b0, 32'h90000000 + 32'(i), 2'b11);
            expect_wr(4'd9, 32'h90000000 + 32'(i), 2'b11, 1'b0, k + i + 1);
            set_mem(1'b1, 4'(10 + i), 1'b0, 32'hC0DE0000 + 32'(i), 2'b11, 1'b0);
            if (i == 3) chk("mem_ready_three_queued", 32'(mem_ready), 32'h1);
            if (i == 4) chk("mem_ready_full", 32'(mem_ready), 32'h0);
            tick();
        end
        set_alu(1'b0, 4'd0, 1'b0, 32'h0, 2'b00);
        set_mem(1'b0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0);
        #1;
        chk("mem_ready_still_full", 32'(mem_ready), 32'h0);
        for (int i = 0; i < 4; i++)
            expect_wr(4'(10 + i), 32'hC0DE0000 + 32'(i), 2'b11, 1'b0, k + 6 + i);
        tick();
        chk("mem_ready_after_pop", 32'(mem_ready), 32'h1);
        tick(); tick(); tick(); tick();
        chk("idle_after_drain", 32'(idle), 32'h1);

        // ---------------- supervisor r15 vs user r15 ----------------
        issue_valid = 1'b1; issue_addr = 4'd15; issue_super = 1'b1;
        tick();
        issue_valid = 1'b0; issue_super = 1'b0;
        supervisor = 1'b0; read1 = 4'd15;
        #1;
        chk("hazard1_user_r15", 32'(hazard1), 32'h0);
        supervisor = 1'b1;
        #1;
        chk("hazard1_ssp", 32'(hazard1), 32'h1);
        set_mem(1'b1, 4'd15, 1'b1, 32'h50000000, 2'b11, 1'b0);
        expect_wr(4'd15, 32'h50000000, 2'b11, 1'b1, cyc + 1);
        tick();
        set_mem(1'b0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0);
        supervisor = 1'b0;
        #1;
        chk("hazard1_user_r15_vs_ssp_write", 32'(hazard1), 32'h0);
        supervisor = 1'b1;
        #1;
        chk("hazard1_ssp_write_cycle", 32'(hazard1), 32'h1);
        tick();
        chk("hazard1_ssp_cleared", 32'(hazard1), 32'h0);
        supervisor = 1'b0; read1 = 4'd0;

        // ---------------- signed loads, unsigned ALU sub-word ----------------
        k = cyc;
        set_mem(1'b1, 4'd2, 1'b0, 32'h00000080, 2'b01, 1'b1);
        expect_wr(4'd2, SE ? 32'hFFFFFF80 : 32'h00000080, SE ? 2'b11 : 2'b01, 1'b0, k + 1);
        tick();
        set_mem(1'b1, 4'd3, 1'b0, 32'h00008001, 2'b10, 1'b1);
        expect_wr(4'd3, SE ? 32'hFFFF8001 : 32'h00008001, SE ? 2'b11 : 2'b10, 1'b0, k + 2);
        tick();
        set_mem(1'b1, 4'd4, 1'b0, 32'hAAAAAA7F, 2'b01, 1'b1);
        expect_wr(4'd4, SE ? 32'h0000007F : 32'hAAAAAA7F, SE ? 2'b11 : 2'b01, 1'b0, k + 3);
        tick();
        set_mem(1'b0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0);
        set_alu(1'b1, 4'd15, 1'b1, 32'h00000080, 2'b01);
        expect_wr(4'd15, 32'h00000080, 2'b01, 1'b1, k + 4);
        tick();
        set_alu(1'b0, 4'd0, 1'b0, 32'h0, 2'b00);
        tick();
        chk("idle_after_signed", 32'(idle), 32'h1);

        // ---------------- reset with 3 loads queued and r4 busy ----------------
        k = cyc;
        issue_valid = 1'b1; issue_addr = 4'd4; issue_super = 1'b0;
        set_alu(1'b1, 4'd1, 1'b0, 32'h00000101, 2'b11);
        expect_wr(4'd1, 32'h00000101, 2'b11, 1'b0, k + 1);
        set_mem(1'b1, 4'd4, 1'b0, 32'h000000D0, 2'b11, 1'b0);
        tick();
        issue_valid = 1'b0;
        set_alu(1'b1, 4'd1, 1'b0, 32'h00000102, 2'b11);
        expect_wr(4'd1, 32'h00000102, 2'b11, 1'b0, k + 2);
        set_mem(1'b1, 4'd7, 1'b0, 32'h000000D1, 2'b11, 1'b0);
        tick();
        // This ALU write is on the port in cycle k+3 and is wiped by reset.
        set_alu(1'b1, 4'd1, 1'b0, 32'h00000103, 2'b11);
        set_mem(1'b1, 4'd8, 1'b0, 32'h000000D2, 2'b11, 1'b0);
        tick();
        set_alu(1'b0, 4'd0, 1'b0, 32'h0, 2'b00);
        set_mem(1'b0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0);
        read1 = 4'd4;
        #1;
        chk("hazard1_r4_before_reset", 32'(hazard1), 32'h1);
        chk("idle_before_reset", 32'(idle), 32'h0);
        rst_i = 1'b0;
        #1;
        chk("midrst_write_en", 32'(write_en), 32'h0);
        chk("midrst_mem_ready", 32'(mem_ready), 32'h1);
        chk("midrst_hazard1_r4", 32'(hazard1), 32'h0);
        chk("midrst_idle", 32'(idle), 32'h1);
        tick(); tick();
        rst_i = 1'b1;
        tick(); tick(); tick();
        chk("post_reset_write_en", 32'(write_en), 32'h0);
        chk("post_reset_idle", 32'(idle), 32'h1);
        read1 = 4'd0;

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
